// File: rtl/uart_rx_fifo.sv
// Receive byte queue between the UART receiver and the CPU read path.
// Circular buffer with occupancy, sticky overflow and a level interrupt.
module uart_rx_fifo #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int IRQ_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_status,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [7:0]        rx_byte,
    output logic              rx_valid,
    output logic              rx_full,
    output logic [ADDR_W:0]   rx_count,
    output logic              rx_overflow,
    output logic              rx_irq
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] IRQ_C   = (ADDR_W+1)'(IRQ_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              irq;

    logic              full;
    logic              valid;
    logic              push;
    logic              pop;
    logic              ovf_event;
    logic [ADDR_W:0]   next_count;
    logic              next_overflow;

    always_comb begin
        full      = (count == DEPTH_C);
        valid     = (count != '0);
        pop       = rd_en & valid;
        // A full queue still accepts a byte when the head leaves on the same edge.
        push      = rx_status & (~full | pop);
        ovf_event = rx_status & full & ~rd_en;

        next_count = count;
        if (push && !pop) begin
            next_count = count + CNT_ONE;
        end else if (pop && !push) begin
            next_count = count - CNT_ONE;
        end

        // Set has priority over the CPU clear.
        next_overflow = ovf_event | (overflow & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= next_count;
            overflow <= next_overflow;
            irq      <= (next_count >= IRQ_C) | next_overflow;
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_comb begin
        rx_byte     = valid ? mem[rd_ptr] : 8'h00;
        rx_valid    = valid;
        rx_full     = full;
        rx_count    = count;
        rx_overflow = overflow;
        rx_irq      = irq;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus reset and IRQ-level sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_status = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;

    logic [7:0] rx_byte,  rx_byte4;
    logic       rx_valid, rx_valid4;
    logic       rx_full,  rx_full4;
    logic [3:0] rx_count, rx_count4;
    logic       rx_overflow, rx_overflow4;
    logic       rx_irq,   rx_irq4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .IRQ_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .rx_status(rx_status), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_full(rx_full), .rx_count(rx_count), .rx_overflow(rx_overflow), .rx_irq(rx_irq)
    );

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .IRQ_LEVEL(4)) dut4 (
        .clk(clk), .reset(reset), .rx_status(rx_status), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rx_byte(rx_byte4), .rx_valid(rx_valid4),
        .rx_full(rx_full4), .rx_count(rx_count4), .rx_overflow(rx_overflow4), .rx_irq(rx_irq4)
    );

    typedef struct {
        int         tag;
        logic       st;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        logic [7:0] e_byte;
        logic       e_valid;
        logic       e_full;
        logic [3:0] e_cnt;
        logic       e_ovf;
        logic       e_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int tag, input logic st, input logic [7:0] d,
                                input logic rd, input logic clr, input logic [7:0] eb,
                                input logic ev, input logic ef, input logic [3:0] ec,
                                input logic eo, input logic ei);
        vec_t v;
        v.tag = tag; v.st = st; v.d = d; v.rd = rd; v.clr = clr;
        v.e_byte = eb; v.e_valid = ev; v.e_full = ef; v.e_cnt = ec;
        v.e_ovf = eo; v.e_irq = ei;
        vecs.push_back(v);
    endfunction

    // Push 01..08 into an empty queue (IRQ_LEVEL=1 instance).
    function automatic void add_fill(input int tag, input logic ovf);
        for (int i = 1; i <= 8; i++)
            add(tag, 1, 8'(i), 0, 0, 8'h01, 1, i == 8, 4'(i), ovf, 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic st, input logic [7:0] d, input logic rd, input logic clr);
        rx_status = st; rx_data = d; rd_en = rd; clr_ovf = clr;
        @(posedge clk);
        #1;
        rx_status = 0; rx_data = 8'h00; rd_en = 0; clr_ovf = 0;
    endtask

    task automatic do_reset();
        #1 reset = 0;
        #12 reset = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: single byte in and out
        add(1, 1, 8'hA5, 0, 0, 8'hA5, 1, 0, 1, 0, 1);
        add(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Test 2: three fill/drain rounds from shifting pointers
        for (int r = 0; r < 3; r++) begin
            add_fill(2, 0);
            for (int i = 1; i <= 8; i++)
                add(2, 0, 8'h00, 1, 0, (i == 8) ? 8'h00 : 8'(i + 1), i != 8, 0, 4'(8 - i), 0, i != 8);
        end
        // Test 3: overflow drops the byte, flag is sticky until cleared
        add_fill(3, 0);
        add(3, 1, 8'h09, 0, 0, 8'h01, 1, 1, 8, 1, 1);
        for (int i = 1; i <= 8; i++)
            add(3, 0, 8'h00, 1, 0, (i == 8) ? 8'h00 : 8'(i + 1), i != 8, 0, 4'(8 - i), 1, 1);
        add(3, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0);
        // Test 4: push and pop together while full
        add_fill(4, 0);
        add(4, 1, 8'hEE, 1, 0, 8'h02, 1, 1, 8, 0, 1);
        for (int k = 1; k <= 8; k++)
            add(4, 0, 8'h00, 1, 0, (k <= 6) ? 8'(k + 2) : ((k == 7) ? 8'hEE : 8'h00),
                k != 8, 0, 4'(8 - k), 0, k != 8);
        // Test 7: push and pop together at count 1, then rd_en on empty
        add(7, 1, 8'h11, 0, 0, 8'h11, 1, 0, 1, 0, 1);
        add(7, 1, 8'h22, 1, 0, 8'h22, 1, 0, 1, 0, 1);
        add(7, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(7, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Test 8: overflow and clear in the same cycle, set wins
        add_fill(8, 0);
        add(8, 1, 8'h55, 0, 1, 8'h01, 1, 1, 8, 1, 1);
        add(8, 0, 8'h00, 0, 1, 8'h01, 1, 1, 8, 0, 1);
        for (int i = 1; i <= 8; i++)
            add(8, 0, 8'h00, 1, 0, (i == 8) ? 8'h00 : 8'(i + 1), i != 8, 0, 4'(8 - i), 0, i != 8);

        do_reset();
        chk("reset_state", {rx_byte, rx_valid, rx_full, rx_count, rx_overflow, rx_irq}, '0);

        foreach (vecs[n]) begin
            apply(vecs[n].st, vecs[n].d, vecs[n].rd, vecs[n].clr);
            chk($sformatf("vec%0d_t%0d", n, vecs[n].tag),
                {rx_byte, rx_valid, rx_full, rx_count, rx_overflow, rx_irq},
                {vecs[n].e_byte, vecs[n].e_valid, vecs[n].e_full, vecs[n].e_cnt,
                 vecs[n].e_ovf, vecs[n].e_irq});
        end

        // Test 5: IRQ_LEVEL=4 threshold
        do_reset();
        for (int i = 1; i <= 3; i++) apply(1, 8'(8'h40 + i), 0, 0);
        chk("t5_irq_at3", {rx_count4, rx_irq4}, {4'd3, 1'b0});
        apply(1, 8'h44, 0, 0);
        chk("t5_irq_at4", {rx_count4, rx_irq4}, {4'd4, 1'b1});
        apply(0, 8'h00, 1, 0);
        chk("t5_irq_pop", {rx_count4, rx_irq4, rx_byte4}, {4'd3, 1'b0, 8'h42});
        for (int i = 0; i < 3; i++) apply(0, 8'h00, 1, 0);
        apply(0, 8'h00, 1, 0);
        chk("t5_rd_empty", {rx_count4, rx_valid4, rx_irq4, rx_overflow4}, {4'd0, 3'b000});

        // Test 6: asynchronous reset mid-stream discards everything
        for (int i = 0; i < 5; i++) apply(1, 8'(8'h70 + i), 0, 0);
        chk("t6_pre_reset", {rx_count, rx_byte}, {4'd5, 8'h70});
        #3 reset = 0;
        #1;
        chk("t6_async_reset", {rx_byte, rx_valid, rx_full, rx_count, rx_overflow, rx_irq}, '0);
        #2 reset = 1;
        @(posedge clk);
        #1;
        apply(1, 8'h3C, 0, 0);
        chk("t6_after_reset", {rx_byte, rx_count, rx_valid}, {8'h3C, 4'd1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART receiver and the pipelined CPU's peripheral read path. It captures each byte that the receiver flags with its one-cycle status pulse and queues it in a small circular FIFO. The CPU pops bytes at its own pace through a read strobe. Occupancy, full, sticky overflow and an interrupt request are exported for the status register and interrupt logic.

Parameters:
DEPTH, 8, number of byte entries; must be a power of 2, 2..256
ADDR_W, 3, log2(DEPTH); width of the read/write pointers
IRQ_LEVEL, 1, occupancy at or above which rx_irq asserts; range 1..DEPTH

Ports:
clk  input  1  system clock; the same clock that the receiver's status pulse is generated on
reset  input  1  asynchronous, active-low reset
rx_status  input  1  one-clk pulse: a new byte is complete on rx_data
rx_data  input  8  received byte; stable on the cycle rx_status is high
rd_en  input  1  CPU pop strobe, one clk per byte
clr_ovf  input  1  CPU write-1 pulse that clears rx_overflow
rx_byte  output  8  head-of-queue byte
rx_valid  output  1  FIFO not empty
rx_full  output  1  count == DEPTH
rx_count  output  ADDR_W+1  current occupancy, 0..DEPTH
rx_overflow  output  1  sticky flag: a byte was dropped
rx_irq  output  1  interrupt request, registered

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- While reset is low, these are all 0: wr_ptr, rd_ptr, count, rx_overflow and rx_irq. As a result rx_byte=0, rx_valid=0, rx_full=0 and rx_count=0.
- Storage array contents are not cleared by reset.
- Reset asserted mid-operation discards all queued bytes immediately, with no drain.
- The push and pop decisions for a cycle are taken on the same rising edge of clk.
- Push condition: push = rx_status & (~rx_full | pop).
  - On push: mem[wr_ptr] <= rx_data, and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop condition: pop = rd_en & rx_valid.
  - On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - rd_en while the FIFO is empty is ignored: no pointer change, no error flag.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - count never exceeds DEPTH and never underflows below 0.
- Simultaneous push and pop when full: both happen.
  - The oldest byte leaves and the new byte is written into the slot it freed (wr_ptr == rd_ptr before the edge).
  - count stays DEPTH; no overflow.
- Simultaneous push and pop when count==1: the head is popped and the new byte becomes the head next cycle; count stays 1.
- Overflow condition: rx_status & rx_full & ~rd_en.
  - The byte is dropped; pointers and count are unchanged.
  - rx_overflow <= 1 on the next edge.
- rx_overflow is cleared only by clr_ovf or by reset.
  - If clr_ovf and a new overflow occur in the same cycle, set wins and rx_overflow stays 1.
- rx_byte = mem[rd_ptr] when count != 0, otherwise 8'h00. This is combinational from registered state.
  - A pushed byte is visible on rx_byte the cycle after the rx_status edge. Latency is 1 clk.
  - After a pop, the next entry is visible the cycle after the rd_en edge.
- rx_valid = (count != 0). rx_full = (count == DEPTH). rx_count = count. All three are derived from the registered count.
- rx_irq <= (next_count >= IRQ_LEVEL) | next_overflow, where next_* are the values being registered this edge.
  - rx_irq is therefore aligned with rx_count and rx_overflow. It is level, not a pulse.
  - It deasserts when the queue drains below IRQ_LEVEL and overflow is clear.
- Pointer width is ADDR_W bits and wraps naturally. count is ADDR_W+1 bits so that full and empty are distinguished without a pointer-compare ambiguity.
- rx_status pulses closer together than 1 clk are not supported; the upstream receiver guarantees at least 150 sample periods between them.

Test Plan:
1. Reset, then a single push of 8'hA5 -> next cycle rx_valid=1, rx_count=1, rx_byte=8'hA5; rd_en pulse -> rx_count=0, rx_valid=0, rx_byte=8'h00.
2. Push 8'h01..8'h08 -> rx_full=1, rx_count=8, rx_overflow=0. Pop 8 times -> bytes read out in order 01..08, then empty. Repeat twice from the shifted pointers to cover wrap-around.
3. Fill to 8, then push 8'h09 with rd_en=0 -> rx_count stays 8, rx_overflow=1, rx_irq=1. Pop all -> 01..08 with no 09. clr_ovf -> rx_overflow=0, rx_irq=0.
4. Full FIFO with rx_status (8'hEE) and rd_en in the same cycle -> 01 popped, count stays 8, no overflow; later pops return 02..08 then EE.
5. IRQ_LEVEL=4 build: push 3 bytes -> rx_irq=0; 4th push -> rx_irq=1 with rx_count=4; one pop -> rx_irq=0. rd_en on empty -> no change, count stays 0.
6. Push 5 bytes, assert reset low mid-stream asynchronously (between edges) -> outputs 0 immediately. Release, push 8'h3C -> rx_byte=8'h3C, rx_count=1 (no stale data).
